inst_fetch_queue: RTL and testbench

//  Parametrised instruction fetch front end. Sits between the AHB-lite instruction port and decode.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/inst_fetch_queue.sv | 133 +++++++++++++
 tb/tb_inst_fetch_queue.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and predecode helpers for the instruction fetch queue.
package fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 64;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } bus_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic              pred_taken;
    } fetch_entry_t;

    // J-type immediate, sign-extended to the widest PC
    function automatic logic [PC_W-1:0] j_imm(input logic [INST_W-1:0] i);
        return {{(PC_W-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // B-type immediate, sign-extended to the widest PC
    function automatic logic [PC_W-1:0] b_imm(input logic [INST_W-1:0] i);
        return {{(PC_W-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry prefetch queue with flush; head is presented combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  din,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  dout,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty
    always_ff @(posedge CLK) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = (count_q != '0) ? mem[rd_ptr] : '0;
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: AHB-lite sequential prefetch, JAL/JALR predecode, epoch-based flush.
// Optional FETCH_BTFN_EN: predict backward conditional branches taken at fill.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_PC,
    output logic [XLEN-1:0] HADDR,
    output logic            HTRANS,
    input  logic            HREADY,
    input  logic [XLEN-1:0] HRDATA,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_PC,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic            pred_taken
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned UW = CW + 1;

    bus_state_t      state_q;
    bus_state_t      state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] txn_addr_q;
    logic            epoch_q;
    logic            txn_epoch_q;
    logic            halt_q;

    logic [CW-1:0]   count;
    logic [UW-1:0]   used;
    logic            issue;
    logic            accept;
    logic            keep;
    logic            is_jal;
    logic            is_jalr;
    logic            btfn_taken;
    logic            flush;
    logic [XLEN-1:0] fill_target;
    logic [INST_W-1:0] word;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Pick the 32-bit slot addressed by the captured fetch address
    if (XLEN == 64) begin : g_slot64
        assign word = HRDATA[{txn_addr_q[2], 5'b0} +: 32];
    end else begin : g_slot32
        assign word = HRDATA[31:0];
    end

`ifdef FETCH_BTFN_EN
    assign btfn_taken = keep && (word[6:0] == OP_BRANCH) && word[31];
`else
    assign btfn_taken = 1'b0;
`endif

    always_comb begin
        used    = UW'(count) + UW'(state_q == DATA);
        issue   = reset && !halt_q && !redirect && (used < UW'(DEPTH));
        accept  = issue && HREADY;
        keep    = (state_q == DATA) && HREADY && (txn_epoch_q == epoch_q) && !redirect;
        is_jal  = keep && (word[6:0] == OP_JAL);
        is_jalr = keep && (word[6:0] == OP_JALR);
        flush   = redirect || is_jal || is_jalr || btfn_taken;
        fill_target = is_jal ? txn_addr_q + XLEN'(j_imm(word))
                             : txn_addr_q + XLEN'(b_imm(word));
        push_entry = '{inst: word, pc: PC_W'(txn_addr_q), pred_taken: btfn_taken};
    end

    // Bus FSM: tracks whether a data phase is outstanding
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ADDR: state_d = accept ? DATA : (issue ? ADDR : IDLE);
            DATA: begin
                if (HREADY) state_d = accept ? DATA : (issue ? ADDR : IDLE);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            txn_addr_q  <= '0;
            epoch_q     <= 1'b0;
            txn_epoch_q <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) txn_addr_q <= fetch_pc_q;
            // A request accepted alongside a flush carries the old epoch and is dropped
            if (accept || flush) txn_epoch_q <= epoch_q;
            if (flush) epoch_q <= ~epoch_q;

            if (redirect)     halt_q <= 1'b0;
            else if (is_jalr) halt_q <= 1'b1;

            if (redirect)                   fetch_pc_q <= redirect_PC;
            else if (is_jal || btfn_taken)  fetch_pc_q <= fill_target;
            else if (accept)                fetch_pc_q <= fetch_pc_q + XLEN'(4);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (keep),
        .din   (push_entry),
        .pop   (inst_valid && inst_ready),
        .flush (redirect),
        .dout  (head),
        .count (count)
    );

    assign HADDR      = fetch_pc_q;
    assign HTRANS     = issue;
    assign inst_valid = (count != '0);
    assign inst       = ILEN'(head.inst);
    assign inst_PC    = XLEN'(head.pc);
    assign pred_taken = head.pred_taken;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue with a one-outstanding AHB-lite slave model.
module tb_inst_fetch_queue;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned DEPTH = 4;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] JAL_100 = 32'h1000_00EF;
    localparam logic [31:0] JALR_X1 = 32'h0000_8067;
    localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;
    localparam logic [31:0] FILLER  = 32'hFFFF_FFFF;

    logic            CLK = 1'b0;
    logic            reset = 1'b1;
    logic            redirect = 1'b0;
    logic [XLEN-1:0] redirect_PC = '0;
    logic [XLEN-1:0] HADDR;
    logic            HTRANS;
    logic            HREADY;
    logic [XLEN-1:0] HRDATA;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] inst_PC;
    logic            inst_valid;
    logic            inst_ready = 1'b0;
    logic            pred_taken;

    int compared   = 0;
    int mismatched = 0;

    always #5 CLK = ~CLK;

    inst_fetch_queue #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC('0)
    ) dut (
        .CLK(CLK), .reset(reset), .redirect(redirect), .redirect_PC(redirect_PC),
        .HADDR(HADDR), .HTRANS(HTRANS), .HREADY(HREADY), .HRDATA(HRDATA),
        .inst(inst), .inst_PC(inst_PC), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .pred_taken(pred_taken)
    );

    // Slave model: NOP everywhere except a small program table, ws wait states per data phase
    logic [XLEN-1:0] prog_addr [4];
    logic [31:0]     prog_word [4];
    int              prog_n = 0;
    int              ws = 0;
    logic            dp_valid;
    logic [XLEN-1:0] dp_addr;
    logic [31:0]     dp_word;
    int              wait_left;

    function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
        for (int i = 0; i < prog_n; i++) if (prog_addr[i] == a) return prog_word[i];
        return NOP;
    endfunction

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            dp_valid  <= 1'b0;
            dp_addr   <= '0;
            dp_word   <= '0;
            wait_left <= 0;
        end else if (HREADY) begin
            dp_valid <= HTRANS;
            if (HTRANS) begin
                dp_addr   <= HADDR;
                dp_word   <= mem_word(HADDR);
                wait_left <= ws;
            end
        end else begin
            wait_left <= wait_left - 1;
        end
    end

    assign HREADY = !(dp_valid && (wait_left != 0));
    assign HRDATA = dp_addr[2] ? {dp_word, FILLER} : {FILLER, dp_word};

    logic [XLEN-1:0] pop_pc   [$];
    logic [31:0]     pop_inst [$];
    logic            pop_pred [$];

    task automatic hold_reset();
        reset = 1'b0; redirect = 1'b0; inst_ready = 1'b0; ws = 0; prog_n = 0;
        pop_pc.delete(); pop_inst.delete(); pop_pred.delete();
        repeat (2) @(negedge CLK);
    endtask

    task automatic collect(input int n);
        repeat (n) begin
            @(negedge CLK); #1;
            if (inst_valid && inst_ready) begin
                pop_pc.push_back(inst_PC);
                pop_inst.push_back(inst);
                pop_pred.push_back(pred_taken);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; #2; reset = 1'b0;
        @(negedge CLK); #1;
        compared++; if (HTRANS !== 1'b0) begin mismatched++; $display("FAIL reset_htrans: got %0h want 0", HTRANS); end
        compared++; if (HADDR !== 64'h0) begin mismatched++; $display("FAIL reset_haddr: got %0h want 0", HADDR); end
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0h want 0", inst_valid); end
        compared++; if (inst !== 32'h0) begin mismatched++; $display("FAIL reset_inst: got %0h want 0", inst); end
        compared++; if (inst_PC !== 64'h0) begin mismatched++; $display("FAIL reset_pc: got %0h want 0", inst_PC); end
        compared++; if (pred_taken !== 1'b0) begin mismatched++; $display("FAIL reset_pred: got %0h want 0", pred_taken); end
    endtask

    task automatic test_sequential();
        hold_reset();
        inst_ready = 1'b1; reset = 1'b1; #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(negedge CLK); #1; end
            compared++; if (HADDR !== 64'(4 * k)) begin mismatched++; $display("FAIL seq_haddr[%0d]: got %0h want %0h", k, HADDR, 4 * k); end
            compared++; if (HTRANS !== 1'b1) begin mismatched++; $display("FAIL seq_htrans[%0d]: got %0h want 1", k, HTRANS); end
            if (k >= 2) begin
                compared++; if (inst_valid !== 1'b1) begin mismatched++; $display("FAIL seq_valid[%0d]: got %0h want 1", k, inst_valid); end
                compared++; if (inst_PC !== 64'(4 * (k - 2))) begin mismatched++; $display("FAIL seq_pc[%0d]: got %0h want %0h", k, inst_PC, 4 * (k - 2)); end
                compared++; if (inst !== NOP) begin mismatched++; $display("FAIL seq_inst[%0d]: got %0h want %0h", k, inst, NOP); end
            end
        end
    endtask

    task automatic test_backpressure();
        hold_reset();
        reset = 1'b1;
        repeat (10) @(negedge CLK);
        #1;
        compared++; if (HTRANS !== 1'b0) begin mismatched++; $display("FAIL bp_htrans: got %0h want 0", HTRANS); end
        compared++; if (HADDR !== 64'(4 * DEPTH)) begin mismatched++; $display("FAIL bp_haddr: got %0h want %0h", HADDR, 4 * DEPTH); end
        compared++; if (inst_PC !== 64'h0) begin mismatched++; $display("FAIL bp_head: got %0h want 0", inst_PC); end
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(negedge CLK); #1; end
            compared++; if (inst_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid[%0d]: got %0h want 1", k, inst_valid); end
            compared++; if (inst_PC !== 64'(4 * k)) begin mismatched++; $display("FAIL bp_pc[%0d]: got %0h want %0h", k, inst_PC, 4 * k); end
        end
    endtask

    task automatic test_jal();
        int hits;
        hold_reset();
        prog_addr[0] = 64'h10; prog_word[0] = JAL_100; prog_n = 1;
        inst_ready = 1'b1; reset = 1'b1;
        collect(16);
        hits = 0;
        foreach (pop_pc[i]) if (pop_pc[i] == 64'h14) hits++;
        compared++; if (hits !== 0) begin mismatched++; $display("FAIL jal_stale_seen: got %0d want 0", hits); end
        compared++;
        if (pop_pc.size() < 7) begin
            mismatched++; $display("FAIL jal_count: got %0d want >=7", pop_pc.size());
        end else begin
            compared++; if (pop_pc[4] !== 64'h10) begin mismatched++; $display("FAIL jal_pc: got %0h want 10", pop_pc[4]); end
            compared++; if (pop_inst[4] !== JAL_100) begin mismatched++; $display("FAIL jal_inst: got %0h want %0h", pop_inst[4], JAL_100); end
            compared++; if (pop_pc[5] !== 64'h110) begin mismatched++; $display("FAIL jal_target: got %0h want 110", pop_pc[5]); end
            compared++; if (pop_pc[6] !== 64'h114) begin mismatched++; $display("FAIL jal_next: got %0h want 114", pop_pc[6]); end
        end
    endtask

    task automatic test_jalr_redirect();
        logic found;
        hold_reset();
        prog_addr[0] = 64'h20; prog_word[0] = JALR_X1; prog_n = 1;
        inst_ready = 1'b1; reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge CLK); #1;
            if (inst_valid && inst_PC == 64'h20) found = 1'b1;
        end
        inst_ready = 1'b0;
        compared++; if (found !== 1'b1) begin mismatched++; $display("FAIL jalr_seen: got %0h want 1", found); end
        compared++; if (HTRANS !== 1'b0) begin mismatched++; $display("FAIL jalr_halt0: got %0h want 0", HTRANS); end
        repeat (3) @(negedge CLK);
        #1;
        compared++; if (HTRANS !== 1'b0) begin mismatched++; $display("FAIL jalr_halt3: got %0h want 0", HTRANS); end
        compared++; if (inst !== JALR_X1) begin mismatched++; $display("FAIL jalr_head: got %0h want %0h", inst, JALR_X1); end
        redirect = 1'b1; redirect_PC = 64'h400; #1;
        compared++; if (HTRANS !== 1'b0) begin mismatched++; $display("FAIL redir_htrans: got %0h want 0", HTRANS); end
        @(negedge CLK); redirect = 1'b0; #1;
        compared++; if (HADDR !== 64'h400) begin mismatched++; $display("FAIL redir_haddr: got %0h want 400", HADDR); end
        compared++; if (HTRANS !== 1'b1) begin mismatched++; $display("FAIL redir_issue: got %0h want 1", HTRANS); end
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL redir_flush: got %0h want 0", inst_valid); end
        inst_ready = 1'b1;
        collect(6);
        compared++;
        if (pop_pc.size() < 2) begin
            mismatched++; $display("FAIL redir_count: got %0d want >=2", pop_pc.size());
        end else begin
            compared++; if (pop_pc[0] !== 64'h400) begin mismatched++; $display("FAIL redir_first: got %0h want 400", pop_pc[0]); end
            compared++; if (pop_pc[1] !== 64'h404) begin mismatched++; $display("FAIL redir_second: got %0h want 404", pop_pc[1]); end
        end
    endtask

    task automatic test_redirect_wait();
        hold_reset();
        ws = 3; inst_ready = 1'b1; reset = 1'b1;
        @(negedge CLK); #1;
        redirect = 1'b1; redirect_PC = 64'h800;
        @(negedge CLK); redirect = 1'b0; #1;
        compared++; if (HADDR !== 64'h800) begin mismatched++; $display("FAIL ws_haddr: got %0h want 800", HADDR); end
        compared++; if (HTRANS !== 1'b1) begin mismatched++; $display("FAIL ws_htrans: got %0h want 1", HTRANS); end
        @(negedge CLK); #1;
        compared++; if (HADDR !== 64'h800) begin mismatched++; $display("FAIL ws_hold: got %0h want 800", HADDR); end
        repeat (2) @(negedge CLK);
        #1;
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL ws_drop: got %0h want 0", inst_valid); end
        collect(30);
        compared++;
        if (pop_pc.size() < 2) begin
            mismatched++; $display("FAIL ws_count: got %0d want >=2", pop_pc.size());
        end else begin
            compared++; if (pop_pc[0] !== 64'h800) begin mismatched++; $display("FAIL ws_first: got %0h want 800", pop_pc[0]); end
            compared++; if (pop_pc[1] !== 64'h804) begin mismatched++; $display("FAIL ws_second: got %0h want 804", pop_pc[1]); end
        end
        ws = 0;
    endtask

    task automatic test_branch();
        logic [XLEN-1:0] exp_next;
        logic            exp_pred;
`ifdef FETCH_BTFN_EN
        exp_next = 64'h28; exp_pred = 1'b1;
`else
        exp_next = 64'h34; exp_pred = 1'b0;
`endif
        hold_reset();
        prog_addr[0] = 64'h30; prog_word[0] = BEQ_M8; prog_n = 1;
        inst_ready = 1'b1; reset = 1'b1;
        collect(30);
        compared++;
        if (pop_pc.size() < 14) begin
            mismatched++; $display("FAIL br_count: got %0d want >=14", pop_pc.size());
        end else begin
            compared++; if (pop_pc[12] !== 64'h30) begin mismatched++; $display("FAIL br_pc: got %0h want 30", pop_pc[12]); end
            compared++; if (pop_pred[12] !== exp_pred) begin mismatched++; $display("FAIL br_pred: got %0h want %0h", pop_pred[12], exp_pred); end
            compared++; if (pop_pc[13] !== exp_next) begin mismatched++; $display("FAIL br_next: got %0h want %0h", pop_pc[13], exp_next); end
            compared++; if (pop_pred[13] !== 1'b0) begin mismatched++; $display("FAIL br_next_pred: got %0h want 0", pop_pred[13]); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_jal();
        test_jalr_redirect();
        test_redirect_wait();
        test_branch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
